// File: rtl/path_player_pkg.sv
// Shared types and constants for the path playback block.
// Direction encodings, list geometry, coordinate width, FSM states.
package path_player_pkg;

  localparam int LIST_DEPTH = 256;
  localparam int IDX_W      = $clog2(LIST_DEPTH);
  localparam int CNT_W      = IDX_W + 1;
  localparam int COORD_W    = 4;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EMIT   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pos_t;

  // Coordinates wrap silently at the grid edge (modulo 2**COORD_W).
  function automatic pos_t step_pos(input pos_t p, input logic [1:0] dir);
    pos_t n;
    n = p;
    case (dir_e'(dir))
      DIR_UP:    n.y = p.y - 1'b1;
      DIR_RIGHT: n.x = p.x + 1'b1;
      DIR_DOWN:  n.y = p.y + 1'b1;
      DIR_LEFT:  n.x = p.x - 1'b1;
      default:   n = p;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/path_player_if.sv
// Solver-facing bundle of the path player: list load, playback request and step outputs.
interface path_player_if;
  import path_player_pkg::*;

  logic               init_list;
  logic               list_push;
  logic [1:0]         dir_in;
  logic               en_read;
  logic               Run;
  logic               Move;
  logic [1:0]         dir_out;
  logic [COORD_W-1:0] x_out;
  logic [COORD_W-1:0] y_out;
  logic               complete_read;
  logic [CNT_W-1:0]   count;
  logic               empty;
  logic               full;
  logic               overflow;
  logic               busy;

  modport master (
    output init_list, list_push, dir_in, en_read, Run,
    input  Move, dir_out, x_out, y_out, complete_read, count, empty, full, overflow, busy
  );

  modport slave (
    input  init_list, list_push, dir_in, en_read, Run,
    output Move, dir_out, x_out, y_out, complete_read, count, empty, full, overflow, busy
  );

endinterface

// File: rtl/path_ram.sv
// 256x2 path list: one write port, one synchronous read port (1-cycle latency).
// Contents are deliberately not reset.
module path_ram
  import path_player_pkg::*;
(
  input  logic             CLK,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [1:0]       wr_dat,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [1:0]       rd_dat
);

  logic [1:0] mem_q [LIST_DEPTH];
  logic [1:0] rd_dat_q;
  logic [1:0] rd_dat_d;

  always_comb begin
    rd_dat_d = rd_dat_q;
    if (rd_en) rd_dat_d = mem_q[rd_addr];
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_addr] <= wr_dat;
    rd_dat_q <= rd_dat_d;
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/path_player.sv
// Stores a solver path and replays it last-in-first-out as Move strobes with rat position.
// One step every 2 cycles; first Move 2 cycles after Run is accepted, complete_read 1 cycle after the last.
module path_player
  import path_player_pkg::*;
(
  input logic         CLK,
  input logic         RST,
  path_player_if.slave pif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  pos_t             pos_q, pos_d;
  logic             overflow_q, overflow_d;

  logic             ram_we;
  logic             ram_re;
  logic [1:0]       ram_rdat;
  logic             is_empty;
  logic             is_full;
  pos_t             pos_nxt;

  path_ram u_ram (
    .CLK     (CLK),
    .wr_en   (ram_we),
    .wr_addr (count_q[IDX_W-1:0]),
    .wr_dat  (pif.dir_in),
    .rd_en   (ram_re),
    .rd_addr (rd_idx_q),
    .rd_dat  (ram_rdat)
  );

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(LIST_DEPTH));
  assign pos_nxt  = step_pos(pos_q, ram_rdat);

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rd_idx_d      = rd_idx_q;
    pos_d         = pos_q;
    overflow_d    = overflow_q;
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    pif.Move          = 1'b0;
    pif.dir_out       = 2'b00;
    pif.complete_read = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pif.init_list) begin
          count_d    = '0;
          overflow_d = 1'b0;
        end else begin
          if (pif.list_push) begin
            if (is_full) begin
              overflow_d = 1'b1;
            end else begin
              ram_we  = 1'b1;
              count_d = count_q + 1'b1;
            end
          end
          if (pif.Run && pif.en_read) begin
            // The list is replayed from its newest entry back to entry 0.
            state_d  = is_empty ? ST_FINISH : ST_FETCH;
            pos_d    = '0;
            rd_idx_d = IDX_W'(count_q - 1'b1);
          end
        end
      end
      ST_FETCH: begin
        ram_re  = 1'b1;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        pif.Move    = 1'b1;
        pif.dir_out = ram_rdat;
        pos_d       = pos_nxt;
        if (rd_idx_q == '0) begin
          state_d = ST_FINISH;
        end else begin
          rd_idx_d = rd_idx_q - 1'b1;
          state_d  = ST_FETCH;
        end
      end
      ST_FINISH: begin
        pif.complete_read = 1'b1;
        state_d           = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Clearing the list mid-playback abandons it without a completion pulse.
    if (pif.init_list && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      count_d    = '0;
      overflow_d = 1'b0;
      pos_d      = pos_q;
      rd_idx_d   = rd_idx_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      rd_idx_q   <= '0;
      pos_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_idx_q   <= rd_idx_d;
      pos_q      <= pos_d;
      overflow_q <= overflow_d;
    end
  end

  assign pif.x_out    = (state_q == ST_EMIT) ? pos_nxt.x : pos_q.x;
  assign pif.y_out    = (state_q == ST_EMIT) ? pos_nxt.y : pos_q.y;
  assign pif.count    = count_q;
  assign pif.empty    = is_empty;
  assign pif.full     = is_full;
  assign pif.overflow = overflow_q;
  assign pif.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_path_player.sv
// Directed-plus-random bench for path_player; a queue-based reference model predicts every output.
module tb_path_player;

  logic CLK;
  logic RST;
  path_player_if pif();

  path_player dut (
    .CLK (CLK),
    .RST (RST),
    .pif (pif.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  int mq[$];
  int movf;
  int px, py;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int d);
    case (d)
      0: py = (py + 15) % 16;
      1: px = (px + 1) % 16;
      2: py = (py + 1) % 16;
      default: px = (px + 15) % 16;
    endcase
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input int d);
    pif.list_push = 1'b1;
    pif.dir_in    = 2'(d);
    next_cycle();
    pif.list_push = 1'b0;
    if (mq.size() == 256) movf = 1;
    else mq.push_back(d);
  endtask

  task automatic do_init();
    pif.init_list = 1'b1;
    next_cycle();
    pif.init_list = 1'b0;
    mq.delete();
    movf = 0;
  endtask

  task automatic check_status(input string tag);
    @(negedge CLK);
    chk({tag, "_count"}, 32'(pif.count), 32'(mq.size()));
    chk({tag, "_empty"}, 32'(pif.empty), 32'(mq.size() == 0));
    chk({tag, "_full"}, 32'(pif.full), 32'(mq.size() == 256));
    chk({tag, "_ovf"}, 32'(pif.overflow), 32'(movf));
    next_cycle();
  endtask

  // Playback with random Run/en_read drop-out and random pushes while busy.
  task automatic play(input string tag);
    int n;
    int idx;
    n   = mq.size();
    idx = n - 1;
    pif.Run     = 1'b1;
    pif.en_read = 1'b1;
    @(negedge CLK);
    chk({tag, "_busy_pre"}, 32'(pif.busy), 32'(0));
    next_cycle();
    pif.Run = 1'b0;
    px = 0;
    py = 0;
    for (int k = 1; k <= 2 * n + 1; k++) begin
      pif.en_read   = 1'($urandom_range(0, 1));
      pif.list_push = 1'($urandom_range(0, 1));
      pif.dir_in    = 2'($urandom_range(0, 3));
      @(negedge CLK);
      chk({tag, "_move"}, 32'(pif.Move), 32'((k % 2 == 0) && (k <= 2 * n)));
      chk({tag, "_cmpl"}, 32'(pif.complete_read), 32'(k == 2 * n + 1));
      if ((k % 2 == 0) && (k <= 2 * n)) begin
        model_step(mq[idx]);
        chk({tag, "_dir"}, 32'(pif.dir_out), 32'(mq[idx]));
        chk({tag, "_x"}, 32'(pif.x_out), 32'(px));
        chk({tag, "_y"}, 32'(pif.y_out), 32'(py));
        idx--;
      end
      next_cycle();
    end
    pif.list_push = 1'b0;
    pif.en_read   = 1'b0;
    @(negedge CLK);
    chk({tag, "_busy_post"}, 32'(pif.busy), 32'(0));
    chk({tag, "_count_post"}, 32'(pif.count), 32'(n));
    chk({tag, "_ovf_post"}, 32'(pif.overflow), 32'(movf));
    next_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    pif.init_list = 1'b0;
    pif.list_push = 1'b0;
    pif.dir_in    = 2'b00;
    pif.en_read   = 1'b0;
    pif.Run       = 1'b0;
    RST  = 1'b0;
    movf = 0;
    #2 RST = 1'b1;
    #1;
    chk("rst_move", 32'(pif.Move), 32'(0));
    chk("rst_dir", 32'(pif.dir_out), 32'(0));
    chk("rst_x", 32'(pif.x_out), 32'(0));
    chk("rst_y", 32'(pif.y_out), 32'(0));
    chk("rst_cmpl", 32'(pif.complete_read), 32'(0));
    chk("rst_count", 32'(pif.count), 32'(0));
    chk("rst_empty", 32'(pif.empty), 32'(1));
    chk("rst_full", 32'(pif.full), 32'(0));
    chk("rst_ovf", 32'(pif.overflow), 32'(0));
    chk("rst_busy", 32'(pif.busy), 32'(0));
    @(posedge CLK);
    @(posedge CLK);
    #1 RST = 1'b0;
    next_cycle();

    // Goal-first path right,right,down replays as down,right,right.
    push(1); push(1); push(2);
    check_status("p3");
    play("basic");
    play("replay");

    do_init();
    check_status("init");
    play("empty");

    do_init(); push(0); play("wrap_y");
    do_init(); push(3); play("wrap_x");

    for (int r = 0; r < 3; r++) begin
      do_init();
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) push($urandom_range(0, 3));
      check_status("rnd");
      play("rnd");
    end

    do_init();
    for (int i = 0; i < 256; i++) push($urandom_range(0, 3));
    check_status("full");
    push($urandom_range(0, 3));
    check_status("ovf");
    play("p256");

    // Clear and push in the same cycle: clear wins and overflow drops.
    pif.init_list = 1'b1;
    pif.list_push = 1'b1;
    next_cycle();
    pif.init_list = 1'b0;
    pif.list_push = 1'b0;
    mq.delete();
    movf = 0;
    check_status("init_push");

    // Abort during the second Move of a 4-step playback.
    for (int i = 0; i < 4; i++) push($urandom_range(0, 3));
    pif.Run     = 1'b1;
    pif.en_read = 1'b1;
    next_cycle();
    pif.Run     = 1'b0;
    pif.en_read = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) pif.init_list = 1'b1;
      @(negedge CLK);
      chk("abort_move", 32'(pif.Move), 32'(k % 2 == 0));
      next_cycle();
    end
    pif.init_list = 1'b0;
    mq.delete();
    for (int k = 5; k <= 10; k++) begin
      @(negedge CLK);
      chk("abort_nomove", 32'(pif.Move), 32'(0));
      chk("abort_nocmpl", 32'(pif.complete_read), 32'(0));
      if (k == 5) begin
        chk("abort_busy", 32'(pif.busy), 32'(0));
        chk("abort_count", 32'(pif.count), 32'(0));
      end
      next_cycle();
    end

    // Asynchronous reset while a Move is on the outputs.
    for (int i = 0; i < 3; i++) push($urandom_range(0, 3));
    pif.Run     = 1'b1;
    pif.en_read = 1'b1;
    next_cycle();
    pif.Run     = 1'b0;
    pif.en_read = 1'b0;
    next_cycle();
    @(negedge CLK);
    chk("mid_move", 32'(pif.Move), 32'(1));
    #1 RST = 1'b1;
    #1;
    chk("mid_rst_move", 32'(pif.Move), 32'(0));
    chk("mid_rst_dir", 32'(pif.dir_out), 32'(0));
    chk("mid_rst_x", 32'(pif.x_out), 32'(0));
    chk("mid_rst_y", 32'(pif.y_out), 32'(0));
    chk("mid_rst_empty", 32'(pif.empty), 32'(1));
    chk("mid_rst_count", 32'(pif.count), 32'(0));
    chk("mid_rst_busy", 32'(pif.busy), 32'(0));
    next_cycle();
    RST = 1'b0;
    mq.delete();
    movf = 0;
    next_cycle();
    push($urandom_range(0, 3));
    play("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/path_player.md
PATH_PLAYER -- requirements
Module: path_player

Interface
REQ-001 CLK  in  1  rising-edge clock.
REQ-002 RST  in  1  reset; asynchronous, active-high.
REQ-003 init_list  in  1  clear the path list (count := 0).
REQ-004 list_push  in  1  append dir_in to the list this cycle.
REQ-005 dir_in  in  2  step direction: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1).
REQ-006 en_read  in  1  solver is in its done/show phase; qualifies Run.
REQ-007 Run  in  1  request path playback.
REQ-008 Move  out  1  one-cycle strobe; dir_out/x_out/y_out describe a valid step.
REQ-009 dir_out  out  2  direction of the current step, same encoding as dir_in.
REQ-010 x_out, y_out  out  4 each  rat position after the current step.
REQ-011 complete_read  out  1  one-cycle pulse; playback finished.
REQ-012 count  out  9  number of stored steps, 0..256.
REQ-013 empty, full  out  1 each  count==0 / count==256.
REQ-014 overflow  out  1  sticky; a push was dropped because the list was full.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 Storage: 256 x 2-bit list; write pointer equals count; pushes are accepted only in IDLE.
REQ-017 Priority: init_list > list_push; init_list and list_push in the same cycle -> count 0, nothing stored, overflow cleared.
REQ-018 Push when full -> data dropped, count unchanged, overflow := 1.
REQ-019 Pushes while busy are ignored, and overflow is not set.
REQ-020 The list is played back LIFO, from the last pushed entry down to entry 0. The solver pushes its path goal-first, so LIFO playback yields start-to-goal order.
REQ-021 FSM states: IDLE, FETCH, EMIT, FINISH.
REQ-022 IDLE -> FETCH when Run & en_read & ~empty; at that edge x/y := (0,0) and rd_idx := count-1.
REQ-023 IDLE -> FINISH when Run & en_read & empty.
REQ-024 FETCH: issue a synchronous read of list[rd_idx] (1-cycle latency); always -> EMIT.
REQ-025 EMIT: Move=1 and dir_out = read data; x_out/y_out are updated combinationally from the registered x/y and registered at the edge.
REQ-026 EMIT transitions: -> FINISH if rd_idx==0, else rd_idx-1 and -> FETCH. Step cadence is one Move every 2 cycles.
REQ-027 Coordinate arithmetic: 4-bit modulo; 0-1 = 15 and 15+1 = 0 with no flag.
REQ-028 FINISH: complete_read=1 for exactly one cycle; -> IDLE. List contents and count are preserved, so replay is possible.
REQ-029 Replay: a new playback starts only from IDLE; if Run & en_read are still high in the IDLE cycle after FINISH, playback restarts from (0,0).
REQ-030 init_list while busy aborts to IDLE at the next edge: count := 0, Move/complete_read = 0, no complete_read pulse.
REQ-031 Deassertion of en_read or Run during playback has no effect; playback runs to completion.
REQ-032 Latency: the first Move occurs 2 cycles after the Run-accept edge; complete_read occurs 1 cycle after the last Move.

Reset
REQ-033 RST -> state IDLE, count 0, rd_idx 0, x/y 0, overflow 0.
REQ-034 During reset: all outputs 0 except empty=1.
REQ-035 List RAM contents are not reset.

Structure
REQ-036 Shared package holds: direction encodings (DIR_UP/RIGHT/DOWN/LEFT), LIST_DEPTH=256, coordinate width 4, FSM state encodings.
REQ-037 One sub-module, path_ram: 256x2 single-write, single-read port, synchronous-read memory.
REQ-038 FSM, pointers and coordinate logic stay in path_player.

Verification
REQ-039 Push 01,01,10 (goal-first), then Run&en_read:
- Move on cycles +2, +4, +6 with dir 10,01,01.
- Positions (0,1),(1,1),(2,1).
- complete_read at +7.
REQ-040 Run&en_read with empty list -> complete_read pulse next cycle, no Move.
REQ-041 Push 256 entries, then one more:
- full=1, overflow=1, count=256.
- Playback emits exactly 256 Moves.
REQ-042 Single entry 00 from (0,0) -> y_out=15 (wrap); entry 11 -> x_out=15.
REQ-043 init_list during the 2nd Move of a 4-step playback:
- IDLE next cycle, count=0.
- No further Move, no complete_read.
REQ-044 RST asserted mid-playback:
- Outputs zero immediately (empty=1).
- A following push+Run plays only the new entry.
